// File: rtl/aes_top.sv
// AES-128 known-answer engine: captures key/plaintext after reset, expands the key,
// encrypts, then decrypts its own ciphertext and holds both results until the next reset.
module aes_top (
   input  logic         clk,
   input  logic         rst,
   input  logic [127:0] key,
   input  logic [127:0] plaintext,
   output logic [127:0] ciphertext,
   output logic [127:0] decrypted_text
);

   typedef enum logic [2:0] {LOAD, KEXP, ENC, DEC, DONE} fsm_t;

   fsm_t          fsm_reg, fsm_next;
   logic [3:0]    rnd_reg, rnd_next;
   logic [127:0]  blk_reg;
   logic [127:0]  rk [0:10];

   logic [127:0]  rk_cur, rk_prev, kexp_next;
   logic [127:0]  sub_bytes, shift_rows, mix_cols, enc_result;
   logic [127:0]  inv_shift, inv_sub, add_key, inv_mix, dec_result;

   // ------------------------------------------------------------------
   // GF(2^8) arithmetic, reduction polynomial 0x11b
   // ------------------------------------------------------------------
   function automatic logic [7:0] xtime(input logic [7:0] a);
      return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] acc;
      logic [7:0] x;
      acc = 8'h00;
      x   = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) acc = acc ^ x;
         x = xtime(x);
      end
      return acc;
   endfunction

   // a^254 is the multiplicative inverse (and maps 0 to 0, as the S-box needs)
   function automatic logic [7:0] gf_inv(input logic [7:0] a);
      logic [7:0] p;
      logic [7:0] acc;
      p   = gf_mul(a, a);
      acc = p;
      for (int i = 0; i < 6; i++) begin
         p   = gf_mul(p, p);
         acc = gf_mul(acc, p);
      end
      return acc;
   endfunction

   function automatic logic [7:0] sbox(input logic [7:0] a);
      logic [7:0] v;
      v = gf_inv(a);
      return v ^ {v[6:0], v[7]} ^ {v[5:0], v[7:6]} ^ {v[4:0], v[7:5]} ^ {v[3:0], v[7:4]} ^ 8'h63;
   endfunction

   function automatic logic [7:0] inv_sbox(input logic [7:0] b);
      logic [7:0] x;
      x = {b[6:0], b[7]} ^ {b[4:0], b[7:5]} ^ {b[1:0], b[7:2]} ^ 8'h05;
      return gf_inv(x);
   endfunction

   function automatic logic [31:0] mix_column(input logic [31:0] w);
      logic [7:0] a0, a1, a2, a3;
      {a0, a1, a2, a3} = w;
      return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
              a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
              a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
              xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
   endfunction

   function automatic logic [31:0] inv_mix_column(input logic [31:0] w);
      logic [7:0] a0, a1, a2, a3;
      {a0, a1, a2, a3} = w;
      return {gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09),
              gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d),
              gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b),
              gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e)};
   endfunction

   function automatic logic [7:0] rcon(input logic [3:0] r);
      logic [7:0] v;
      case (r)
         4'd1:    v = 8'h01;
         4'd2:    v = 8'h02;
         4'd3:    v = 8'h04;
         4'd4:    v = 8'h08;
         4'd5:    v = 8'h10;
         4'd6:    v = 8'h20;
         4'd7:    v = 8'h40;
         4'd8:    v = 8'h80;
         4'd9:    v = 8'h1b;
         4'd10:   v = 8'h36;
         default: v = 8'h00;
      endcase
      return v;
   endfunction

   // ------------------------------------------------------------------
   // Round-key selection and one step of key expansion
   // ------------------------------------------------------------------
   always_comb begin
      logic [31:0] w0, w1, w2, w3, tmp;
      rk_cur  = (rnd_reg <= 4'd10) ? rk[rnd_reg] : '0;
      rk_prev = (rnd_reg >= 4'd1 && rnd_reg <= 4'd11) ? rk[rnd_reg - 4'd1] : '0;
      {w0, w1, w2, w3} = rk_prev;
      tmp = {sbox(w3[23:16]), sbox(w3[15:8]), sbox(w3[7:0]), sbox(w3[31:24])}
            ^ {rcon(rnd_reg), 24'h000000};
      w0 = w0 ^ tmp;
      w1 = w1 ^ w0;
      w2 = w2 ^ w1;
      w3 = w3 ^ w2;
      kexp_next = {w0, w1, w2, w3};
   end

   // ------------------------------------------------------------------
   // Byte-wise round transforms; byte gi sits at row gi%4, column gi/4
   // ------------------------------------------------------------------
   genvar gi;
   generate
      for (gi = 0; gi < 16; gi++) begin : g_byte
         localparam int ROW     = gi % 4;
         localparam int COL     = gi / 4;
         localparam int SR_SRC  = ROW + 4 * ((COL + ROW) % 4);
         localparam int ISR_SRC = ROW + 4 * ((COL - ROW + 4) % 4);
         assign sub_bytes[127-8*gi -: 8]  = sbox(blk_reg[127-8*gi -: 8]);
         assign shift_rows[127-8*gi -: 8] = sub_bytes[127-8*SR_SRC -: 8];
         assign inv_shift[127-8*gi -: 8]  = blk_reg[127-8*ISR_SRC -: 8];
         assign inv_sub[127-8*gi -: 8]    = inv_sbox(inv_shift[127-8*gi -: 8]);
      end
      for (gi = 0; gi < 4; gi++) begin : g_col
         assign mix_cols[127-32*gi -: 32] = mix_column(shift_rows[127-32*gi -: 32]);
         assign inv_mix[127-32*gi -: 32]  = inv_mix_column(add_key[127-32*gi -: 32]);
      end
   endgenerate

   assign enc_result = ((rnd_reg == 4'd10) ? shift_rows : mix_cols) ^ rk_cur;
   assign add_key    = inv_sub ^ rk_cur;
   assign dec_result = (rnd_reg == 4'd0) ? add_key : inv_mix;

   // ------------------------------------------------------------------
   // Control FSM
   // ------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fsm_reg <= LOAD;
         rnd_reg <= 4'd0;
      end else begin
         fsm_reg <= fsm_next;
         rnd_reg <= rnd_next;
      end
   end

   always_comb begin
      fsm_next = fsm_reg;
      rnd_next = rnd_reg;
      case (fsm_reg)
         LOAD: begin
            fsm_next = KEXP;
            rnd_next = 4'd1;
         end
         KEXP: begin
            if (rnd_reg == 4'd10) begin
               fsm_next = ENC;
               rnd_next = 4'd1;
            end else begin
               rnd_next = rnd_reg + 4'd1;
            end
         end
         ENC: begin
            if (rnd_reg == 4'd10) begin
               fsm_next = DEC;
               rnd_next = 4'd9;
            end else begin
               rnd_next = rnd_reg + 4'd1;
            end
         end
         DEC: begin
            if (rnd_reg == 4'd0) fsm_next = DONE;
            else                 rnd_next = rnd_reg - 4'd1;
         end
         default: ;
      endcase
   end

   // ------------------------------------------------------------------
   // Datapath registers
   // ------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         blk_reg        <= '0;
         ciphertext     <= '0;
         decrypted_text <= '0;
         for (int i = 0; i < 11; i++) rk[i] <= '0;
      end else begin
         case (fsm_reg)
            LOAD: begin
               rk[0]   <= key;
               blk_reg <= plaintext ^ key;
            end
            KEXP: rk[rnd_reg] <= kexp_next;
            ENC: begin
               if (rnd_reg == 4'd10) begin
                  ciphertext <= enc_result;
                  // strip the last round key so decryption starts from ShiftRows(SubBytes(.))
                  blk_reg    <= enc_result ^ rk_cur;
               end else begin
                  blk_reg    <= enc_result;
               end
            end
            DEC: begin
               blk_reg <= dec_result;
               if (rnd_reg == 4'd0) decrypted_text <= dec_result;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_aes_top.sv
// Self-checking bench for aes_top: known-answer vectors, latency/reset behaviour and
// random vectors compared against a byte-array AES-128 reference model.
module tb_aes_top;

   logic         clk;
   logic         rst;
   logic [127:0] key;
   logic [127:0] plaintext;
   logic [127:0] ciphertext;
   logic [127:0] decrypted_text;

   int checks = 0;
   int errors = 0;

   logic [7:0] sbox_tab [256];

   localparam logic [127:0] B_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [127:0] B_PT  = 128'h3243f6a8885a308d313198a2e0370734;
   localparam logic [127:0] B_CT  = 128'h3925841d02dc09fbdc118597196a0b32;
   localparam logic [127:0] C_KEY = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] C_PT  = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] C_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
   localparam logic [127:0] Z_CT  = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;

   aes_top dut (
      .clk            (clk),
      .rst            (rst),
      .key            (key),
      .plaintext      (plaintext),
      .ciphertext     (ciphertext),
      .decrypted_text (decrypted_text)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [7:0] xt(input logic [7:0] a);
      return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
   endfunction

   // S-box built by walking the multiplicative group with generator 3 and its inverse
   task automatic build_sbox();
      logic [7:0] p, q, x;
      p = 8'h01;
      q = 8'h01;
      do begin
         p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
         q = q ^ {q[6:0], 1'b0};
         q = q ^ {q[5:0], 2'b00};
         q = q ^ {q[3:0], 4'h0};
         if (q[7]) q = q ^ 8'h09;
         x = q ^ {q[6:0], q[7]} ^ {q[5:0], q[7:6]} ^ {q[4:0], q[7:5]} ^ {q[3:0], q[7:4]};
         sbox_tab[p] = x ^ 8'h63;
      end while (p != 8'h01);
      sbox_tab[0] = 8'h63;
   endtask

   function automatic logic [127:0] ref_encrypt(input logic [127:0] k, input logic [127:0] p);
      logic [31:0]  w [44];
      logic [31:0]  tmp;
      logic [7:0]   rc;
      logic [7:0]   s [16];
      logic [7:0]   t [16];
      logic [7:0]   a0, a1, a2, a3;
      logic [127:0] res;
      for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
      rc = 8'h01;
      for (int i = 4; i < 44; i++) begin
         tmp = w[i-1];
         if (i % 4 == 0) begin
            tmp = {sbox_tab[tmp[23:16]], sbox_tab[tmp[15:8]], sbox_tab[tmp[7:0]], sbox_tab[tmp[31:24]]}
                  ^ {rc, 24'h000000};
            rc = xt(rc);
         end
         w[i] = w[i-4] ^ tmp;
      end
      for (int i = 0; i < 16; i++) s[i] = p[127-8*i -: 8] ^ w[i/4][31-8*(i%4) -: 8];
      for (int rd = 1; rd <= 10; rd++) begin
         for (int i = 0; i < 16; i++) s[i] = sbox_tab[s[i]];
         for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
               t[r+4*c] = s[r+4*((c+r)%4)];
         for (int c = 0; c < 4; c++) begin
            a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
            if (rd < 10) begin
               s[4*c]   = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
               s[4*c+1] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
               s[4*c+2] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
               s[4*c+3] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
            end else begin
               s[4*c] = a0; s[4*c+1] = a1; s[4*c+2] = a2; s[4*c+3] = a3;
            end
         end
         for (int i = 0; i < 16; i++) s[i] = s[i] ^ w[4*rd + i/4][31-8*(i%4) -: 8];
      end
      for (int i = 0; i < 16; i++) res[127-8*i -: 8] = s[i];
      return res;
   endfunction

   task automatic check(input string tag, input int edge_n, input logic [127:0] obs,
                        input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s edge %0d: observed %h expected %h", tag, edge_n, obs, exp);
      end
   endtask

   // Assert reset mid-cycle: outputs must clear without waiting for a clock edge.
   task automatic apply_reset();
      @(negedge clk);
      rst = 1'b1;
      #1;
      check("rst_async_ct", 0, ciphertext, '0);
      check("rst_async_dec", 0, decrypted_text, '0);
      repeat (3) begin
         @(posedge clk);
         #1;
         check("rst_hold_ct", 0, ciphertext, '0);
         check("rst_hold_dec", 0, decrypted_text, '0);
      end
   endtask

   // Release reset and follow edges 1..31 of a run.
   task automatic run_and_check(input string tag, input logic [127:0] k, input logic [127:0] p,
                                input logic [127:0] exp_ct, input bit switch_inputs);
      key       = k;
      plaintext = p;
      @(negedge clk);
      rst = 1'b0;
      for (int e = 1; e <= 31; e++) begin
         if (switch_inputs && e == 5) begin
            key       = C_KEY;
            plaintext = C_PT;
         end
         @(posedge clk);
         #1;
         check({tag, "_ct"}, e, ciphertext, (e >= 21) ? exp_ct : 128'h0);
         check({tag, "_dec"}, e, decrypted_text, (e >= 31) ? p : 128'h0);
      end
   endtask

   initial begin
      logic [127:0] rk_v, rp_v;
      rst       = 1'b1;
      key       = B_KEY;
      plaintext = B_PT;
      build_sbox();

      // App. B with latency checks, then long-term stability
      apply_reset();
      run_and_check("appB", B_KEY, B_PT, B_CT, 1'b0);
      for (int i = 0; i < 1000; i++) begin
         key       = $urandom_range(0, 1) ? C_KEY : {4{$urandom}};
         plaintext = {4{$urandom}};
         @(posedge clk);
         #1;
         if (i % 100 == 99) begin
            check("stable_ct", 31 + i + 1, ciphertext, B_CT);
            check("stable_dec", 31 + i + 1, decrypted_text, B_PT);
         end
      end

      // Inputs switched to C.1 before edge 5 must not disturb the App. B run
      apply_reset();
      run_and_check("late_inputs", B_KEY, B_PT, B_CT, 1'b1);

      // Reset during encryption, then a clean C.1 run
      apply_reset();
      key       = C_KEY;
      plaintext = C_PT;
      @(negedge clk);
      rst = 1'b0;
      repeat (14) @(posedge clk);
      @(posedge clk);
      rst = 1'b1;
      #1;
      check("midenc_rst_ct", 15, ciphertext, '0);
      check("midenc_rst_dec", 15, decrypted_text, '0);
      repeat (2) @(posedge clk);
      run_and_check("appC1", C_KEY, C_PT, C_CT, 1'b0);

      // All-zero key and plaintext
      apply_reset();
      run_and_check("zero", 128'h0, 128'h0, Z_CT, 1'b0);

      // Random vectors against the reference model
      for (int n = 0; n < 4; n++) begin
         rk_v = {$urandom, $urandom, $urandom, $urandom};
         rp_v = {$urandom, $urandom, $urandom, $urandom};
         apply_reset();
         run_and_check("rand", rk_v, rp_v, ref_encrypt(rk_v, rp_v), 1'b0);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
